// File: rtl/ifetch.sv
// Instruction fetch unit: keeps at most one memory request in flight and
// presents fetched instructions on a valid/stall handshake with branch redirect.
module ifetch #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] imem_addr,
   output logic             imem_enable,
   input  logic [WIDTH-1:0] imem_data,
   input  logic             imem_ready,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             stall,
   output logic [WIDTH-1:0] instr_out,
   output logic [WIDTH-1:0] pc_out,
   output logic             instr_valid
);

   typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DRAIN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] pco_q, pco_d;
   logic             vld_q, vld_d;
   logic             run_q;
   logic [WIDTH-1:0] target_al;

   assign target_al = {branch_target[WIDTH-1:2], 2'b00};

   // run_q delays the first request by one edge so that reset release only
   // takes effect at the next clock edge.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         pco_q   <= '0;
         vld_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
         vld_q   <= vld_d;
         run_q   <= 1'b1;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      pco_d       = pco_q;
      vld_d       = vld_q;
      imem_enable = 1'b0;

      if (vld_q && !stall) vld_d = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (branch_taken) begin
               pc_d = target_al;
            end else if (run_q && !(vld_q && stall)) begin
               imem_enable = 1'b1;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem_ready) begin
               state_d = ST_FETCH;
               if (!branch_taken) begin
                  instr_d = imem_data;
                  pco_d   = pc_q;
                  vld_d   = 1'b1;
                  pc_d    = pc_q + WIDTH'(4);
               end
            end
            // A redirect with the response still pending must swallow it later.
            if (branch_taken) begin
               pc_d = target_al;
               if (!imem_ready) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (branch_taken) pc_d = target_al;
            if (imem_ready) state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase

      if (branch_taken) vld_d = 1'b0;
   end

   assign imem_addr   = pc_q;
   assign instr_out   = instr_q;
   assign pc_out      = pco_q;
   assign instr_valid = vld_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a latency-programmable instruction memory, a transaction
// model tracking the outstanding request, and directed plus random steps.
module tb_ifetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // instance A (RESET_PC = 0)
   logic        rst_a, a_en, a_ready, a_vld, branch, stall;
   logic [31:0] a_addr, a_data, a_instr, a_pco, tgt;
   // instance B (RESET_PC = 0xFFFF_FFFC)
   logic        rst_b, b_en, b_vld;
   logic [31:0] b_addr, b_data, b_instr, b_pco;
   logic        b_rdy_q = 1'b0;
   logic [31:0] b_aq = '0;

   int total = 0;
   int bad   = 0;

   // memory content: a closed-form function of the word address
   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h13 + (a << 5);
   endfunction

   ifetch u_a (
      .clk(clk), .reset(rst_a), .imem_addr(a_addr), .imem_enable(a_en),
      .imem_data(a_data), .imem_ready(a_ready), .branch_taken(branch),
      .branch_target(tgt), .stall(stall), .instr_out(a_instr),
      .pc_out(a_pco), .instr_valid(a_vld)
   );

   ifetch #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_b (
      .clk(clk), .reset(rst_b), .imem_addr(b_addr), .imem_enable(b_en),
      .imem_data(b_data), .imem_ready(b_rdy_q), .branch_taken(1'b0),
      .branch_target(32'h0), .stall(1'b0), .instr_out(b_instr),
      .pc_out(b_pco), .instr_valid(b_vld)
   );

   // memory A: responds mem_lat cycles after sampling a request; inj_ready
   // forces a spurious response pulse
   int          mem_lat   = 1;
   int          pend_cnt  = 0;
   logic [31:0] pend_addr = '0;
   logic        inj_ready = 1'b0;

   always @(posedge clk) begin
      if (a_en) begin
         pend_cnt  <= mem_lat;
         pend_addr <= a_addr;
      end else if (pend_cnt != 0) begin
         pend_cnt <= pend_cnt - 1;
      end
   end
   assign a_ready = inj_ready || (pend_cnt == 1);
   assign a_data  = inj_ready ? 32'hBAD0_0000 : ((pend_cnt == 1) ? word(pend_addr) : 32'h0);

   // memory B: fixed one-cycle latency
   always @(posedge clk) begin
      b_rdy_q <= b_en;
      b_aq    <= b_addr;
   end
   assign b_data = b_rdy_q ? word(b_aq) : 32'h0;

   // transaction model of instance A
   bit          m_live, m_busy, m_poison, m_vld;
   logic [31:0] m_pc, m_pco, m_ins;

   task automatic model_reset();
      m_live = 0; m_busy = 0; m_poison = 0; m_vld = 0;
      m_pc = 32'h0; m_pco = 32'h0; m_ins = 32'h0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // check the current cycle against the model, then advance one clock
   task automatic step();
      bit          en, resp, cons;
      bit          n_live, n_busy, n_poison, n_vld;
      logic [31:0] n_pc, n_pco, n_ins;
      #1;
      if (!rst_a) model_reset();
      en = m_live && rst_a && !m_busy && !branch && !(m_vld && stall);
      chk("enable", {31'b0, a_en}, {31'b0, en});
      chk("addr", a_addr, m_pc);
      chk("valid", {31'b0, a_vld}, {31'b0, m_vld});
      if (m_vld || !rst_a) begin
         chk("pc_out", a_pco, m_pco);
         chk("instr_out", a_instr, m_ins);
      end
      n_live = m_live; n_busy = m_busy; n_poison = m_poison; n_vld = m_vld;
      n_pc = m_pc; n_pco = m_pco; n_ins = m_ins;
      if (rst_a && !m_live) begin
         n_live = 1;
      end else if (rst_a) begin
         cons = m_vld && !stall;
         resp = a_ready && m_busy;
         if (cons) n_vld = 0;
         if (resp) begin
            n_busy = 0; n_poison = 0;
            if (!m_poison && !branch) begin
               n_vld = 1; n_pco = m_pc; n_ins = a_data; n_pc = m_pc + 32'd4;
            end
         end
         if (branch) begin
            n_pc  = {tgt[31:2], 2'b00};
            n_vld = 0;
            if (m_busy && !resp) n_poison = 1;
         end
         if (en) n_busy = 1;
      end
      @(posedge clk);
      @(negedge clk);
      m_live = n_live; m_busy = n_busy; m_poison = n_poison; m_vld = n_vld;
      m_pc = n_pc; m_pco = n_pco; m_ins = n_ins;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_a = 0; rst_b = 0; branch = 0; stall = 0; tgt = '0;
      model_reset();
      @(negedge clk);

      // reset state
      #1;
      chk("rst_valid", {31'b0, a_vld}, 32'd0);
      chk("rst_en", {31'b0, a_en}, 32'd0);
      chk("rst_addr", a_addr, 32'h0);
      chk("rst_b_addr", b_addr, 32'hFFFF_FFFC);
      chk("rst_b_en", {31'b0, b_en}, 32'd0);
      step();
      step();

      // reset release and back-to-back fetches
      rst_a = 1;
      step(); step(); step();
      chk("seq0_valid", {31'b0, a_vld}, 32'd1);
      chk("seq0_pc", a_pco, 32'h0);
      chk("seq0_ins", a_instr, 32'h13);
      step(); step();
      chk("seq1_pc", a_pco, 32'h4);
      chk("seq1_ins", a_instr, 32'h93);

      // stall holds outputs and blocks requests
      stall = 1; mem_lat = 3;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", {31'b0, a_vld}, 32'd1);
         chk("stall_pc", a_pco, 32'h4);
         chk("stall_en", {31'b0, a_en}, 32'd0);
      end
      stall = 0;
      #1;
      chk("stall_drop_en", {31'b0, a_en}, 32'd1);
      chk("stall_drop_addr", a_addr, 32'h8);
      step();

      // redirect while the request for 8 is still outstanding
      branch = 1; tgt = 32'h41;
      step();
      branch = 0; mem_lat = 1;
      chk("drain_addr", a_addr, 32'h40);
      n = 0;
      while (!a_vld && n < 12) begin step(); n++; end
      chk("drain_valid", {31'b0, a_vld}, 32'd1);
      chk("drain_pc", a_pco, 32'h40);
      chk("drain_ins", a_instr, word(32'h40));

      // redirect in the same cycle as the response
      step();
      branch = 1; tgt = 32'h1234_567B;
      step();
      branch = 0;
      #1;
      chk("sim_valid", {31'b0, a_vld}, 32'd0);
      chk("sim_addr", a_addr, 32'h1234_5678);
      chk("sim_en", {31'b0, a_en}, 32'd1);
      step(); step();
      chk("sim_next_valid", {31'b0, a_vld}, 32'd1);
      chk("sim_next_pc", a_pco, 32'h1234_5678);

      // reset while waiting, spurious response right after release
      step();
      rst_a = 0;
      #1;
      chk("mid_rst_valid", {31'b0, a_vld}, 32'd0);
      chk("mid_rst_pc", a_pco, 32'h0);
      chk("mid_rst_en", {31'b0, a_en}, 32'd0);
      chk("mid_rst_addr", a_addr, 32'h0);
      step(); step();
      rst_a = 1; inj_ready = 1;
      step();
      chk("late_valid1", {31'b0, a_vld}, 32'd0);
      step();
      inj_ready = 0;
      chk("late_valid2", {31'b0, a_vld}, 32'd0);
      step();
      chk("late_first_valid", {31'b0, a_vld}, 32'd1);
      chk("late_first_pc", a_pco, 32'h0);
      chk("late_first_ins", a_instr, 32'h13);

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         stall   = ($urandom_range(0, 2) == 0);
         branch  = ($urandom_range(0, 7) == 0);
         tgt     = $urandom;
         mem_lat = $urandom_range(1, 3);
         step();
      end
      stall = 0; branch = 0; mem_lat = 1;
      for (int i = 0; i < 6; i++) step();

      // address wrap from the top of the space
      rst_b = 1;
      step(); step(); step();
      chk("wrap_valid0", {31'b0, b_vld}, 32'd1);
      chk("wrap_pc0", b_pco, 32'hFFFF_FFFC);
      chk("wrap_ins0", b_instr, word(32'hFFFF_FFFC));
      step(); step();
      chk("wrap_valid1", {31'b0, b_vld}, 32'd1);
      chk("wrap_pc1", b_pco, 32'h0);
      chk("wrap_ins1", b_instr, 32'h13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter WIDTH, default 32: width of addresses and instructions.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = in reset); deassertion takes effect at the next clk edge.
REQ-005 imem_addr  output  WIDTH  fetch address to instruction memory.
REQ-006 imem_enable  output  1  fetch request strobe; memory samples it on clk edge.
REQ-007 imem_data  input  WIDTH  instruction returned by memory; valid only while imem_ready=1.
REQ-008 imem_ready  input  1  one-cycle response pulse, in the cycle after the edge that sampled imem_enable=1.
REQ-009 branch_taken  input  1  redirect request, one cycle.
REQ-010 branch_target  input  WIDTH  redirect address; bits [1:0] ignored, treated as 0.
REQ-011 stall  input  1  downstream not accepting instr_out this cycle.
REQ-012 instr_out  output  WIDTH  fetched instruction.
REQ-013 pc_out  output  WIDTH  address of instr_out.
REQ-014 instr_valid  output  1  instr_out/pc_out valid; consumed at an edge where instr_valid=1 and stall=0.

Function
REQ-015 The block SHALL implement FSM states FETCH, WAIT, DRAIN; at most one memory request outstanding.
REQ-016 FETCH: imem_enable SHALL be 1 combinationally iff !branch_taken and !(instr_valid and stall); imem_addr SHALL equal pc in every state.
REQ-017 FETCH -> WAIT on an edge where imem_enable=1; otherwise stay FETCH.
REQ-018 WAIT: imem_enable=0; on imem_ready=1 and !branch_taken, SHALL load instr_out<=imem_data, pc_out<=pc, instr_valid<=1, pc<=pc+4 (mod 2^WIDTH, wrap 0xFFFF_FFFC -> 0), next FETCH.
REQ-019 WAIT with imem_ready=0 SHALL stay WAIT indefinitely (no timeout).
REQ-020 branch_taken in FETCH: pc<=branch_target&~3, no request issued, stay FETCH.
REQ-021 branch_taken in WAIT with imem_ready=0: pc<=target&~3, next DRAIN; the pending response SHALL be discarded.
REQ-022 branch_taken in WAIT with imem_ready=1 (simultaneous): data discarded, pc<=target&~3, next FETCH.
REQ-023 DRAIN: imem_enable=0; on imem_ready=1, drop data, next FETCH; branch_taken in DRAIN updates pc only, stays DRAIN.
REQ-024 branch_taken SHALL clear instr_valid at that edge regardless of stall.
REQ-025 instr_valid SHALL clear at an edge with instr_valid=1, stall=0, unless reloaded per REQ-018 at that edge; with stall=1, instr_out/pc_out/instr_valid SHALL hold.
REQ-026 imem_ready SHALL be ignored in FETCH.
REQ-027 Steady-state throughput: one instruction per 2 cycles with stall=0; first instr_valid=1 at third edge after reset deassertion.

Reset
REQ-028 On reset=0, immediately: state=FETCH, pc=RESET_PC, instr_valid=0, instr_out=0, pc_out=0; imem_enable follows REQ-016 (0 because no edge yet required, output combinational from reset state is 1 only once reset=1).
REQ-029 imem_enable SHALL be 0 while reset=0.
REQ-030 Reset asserted mid-WAIT/DRAIN SHALL abandon the request; a late imem_ready after deassertion is ignored per REQ-026.

Verification
REQ-031 Reset release, memory words 0x13,0x93,0x113 at 0,4,8, stall=0 -> instr_valid pulses with (pc_out,instr_out)=(0,0x13),(4,0x93),(8,0x113), every 2 cycles.
REQ-032 stall=1 for 5 cycles while instr_valid=1 at pc_out=4 -> outputs hold, imem_enable=0 throughout, fetch of 8 starts the cycle stall drops.
REQ-033 branch_taken with target 0x41 during WAIT for addr 8 -> response for 8 dropped, next imem_addr=0x40, next pc_out=0x40.
REQ-034 branch_taken simultaneous with imem_ready -> no instr_valid for that data, next fetch at target, state FETCH next cycle.
REQ-035 RESET_PC=0xFFFF_FFFC, stall=0 -> pc_out sequence 0xFFFF_FFFC then 0x0000_0000.
REQ-036 reset asserted in WAIT, imem_ready pulses the cycle after deassertion -> no instr_valid, first fetch at RESET_PC.
